// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream, memory-write and status bundle for imem_loader.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface imem_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    // Stimulus / host side: drives the byte stream and the memory handshake.
    modport master (
        output start, in_valid, in_data, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, checksum
    );

    // Loader side.
    modport slave (
        input  start, in_valid, in_data, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, checksum
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Assembles a length-prefixed LE byte stream into 32-bit words and
//               writes them sequentially into instruction memory from BASE_ADDR.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int unsigned WORDS     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    imem_loader_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [31:0] c_words = 32'(WORDS);

    logic [2:0]  state_q, state_d;
    logic [1:0]  bcnt_q;
    logic [31:0] n_q;
    logic [31:0] idx_q;
    logic [31:0] word_q;
    logic [31:0] addr_q;
    logic [31:0] csum_q;

    logic        ready_dec, we_dec, hold_dec, done_dec, err_dec;
    logic        start_ok, byte_fire, wr_fire, last_byte;
    logic [31:0] n_full, idx_inc;

    assign start_ok  = bus.start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
    assign byte_fire = bus.in_valid & ready_dec;
    assign wr_fire   = we_dec & bus.mem_ready;
    assign last_byte = byte_fire & (bcnt_q == 2'd3);
    // Length as it will be once the current (4th) byte lands.
    assign n_full    = {bus.in_data, n_q[23:0]};
    assign idx_inc   = idx_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) state_d = S_LEN;
            end
            S_LEN: begin
                if (last_byte) begin
                    if (n_full == 32'd0)        state_d = S_DONE;
                    else if (n_full > c_words)  state_d = S_ERR;
                    else                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (last_byte) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus.mem_ready) state_d = (idx_inc == n_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_dec = 1'b0;
        we_dec    = 1'b0;
        hold_dec  = 1'b0;
        done_dec  = 1'b0;
        err_dec   = 1'b0;
        case (state_q)
            S_LEN, S_DATA: begin
                ready_dec = 1'b1;
                hold_dec  = 1'b1;
            end
            S_WRITE: begin
                we_dec   = 1'b1;
                hold_dec = 1'b1;
            end
            S_DONE:  done_dec = 1'b1;
            S_ERR:   err_dec  = 1'b1;
            default: ;
        endcase
    end

    // The word register doubles as mem_wdata; it cannot change in WRITE since no
    // bytes are accepted there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcnt_q <= 2'd0;
            n_q    <= 32'd0;
            idx_q  <= 32'd0;
            word_q <= 32'd0;
            addr_q <= BASE_ADDR;
            csum_q <= 32'd0;
        end else begin
            if (start_ok) begin
                bcnt_q <= 2'd0;
                n_q    <= 32'd0;
                idx_q  <= 32'd0;
                addr_q <= BASE_ADDR;
                csum_q <= 32'd0;
            end
            if (byte_fire) begin
                bcnt_q <= bcnt_q + 2'd1;
                if (state_q == S_LEN) begin
                    n_q[8*bcnt_q +: 8] <= bus.in_data;
                end else begin
                    word_q[8*bcnt_q +: 8] <= bus.in_data;
                end
            end
            if (wr_fire) begin
                csum_q <= csum_q + word_q;
                idx_q  <= idx_inc;
                addr_q <= addr_q + 32'd4;
            end
        end
    end

    assign bus.in_ready  = ready_dec;
    assign bus.mem_we    = we_dec;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = word_q;
    assign bus.cpu_hold  = hold_dec;
    assign bus.done      = done_dec;
    assign bus.error     = err_dec;
    assign bus.checksum  = csum_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    imem_loader_if bus();

    imem_loader #(
        .WORDS     (4096),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wa [0:8191];
    logic [31:0] wd [0:8191];
    int wr_cnt    = 0;
    int we_cycles = 0;

    always @(posedge clk) begin
        if (bus.mem_we) we_cycles <= we_cycles + 1;
        if (bus.mem_we && bus.mem_ready && wr_cnt < 8192) begin
            wa[wr_cnt] <= bus.mem_addr;
            wd[wr_cnt] <= bus.mem_wdata;
            wr_cnt     <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) check("in_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_end();
        int g;
        g = 0;
        while (!(bus.done || bus.error) && g < 500) begin
            tick();
            g++;
        end
        if (g >= 500) check("done_timeout", {31'b0, bus.done}, 32'd1);
    endtask

    task automatic check_reset(input string p);
        check({p, "_in_ready"},  {31'b0, bus.in_ready}, 32'd0);
        check({p, "_mem_we"},    {31'b0, bus.mem_we},   32'd0);
        check({p, "_mem_addr"},  bus.mem_addr,          32'h0000_0000);
        check({p, "_mem_wdata"}, bus.mem_wdata,         32'd0);
        check({p, "_cpu_hold"},  {31'b0, bus.cpu_hold}, 32'd0);
        check({p, "_done"},      {31'b0, bus.done},     32'd0);
        check({p, "_error"},     {31'b0, bus.error},    32'd0);
        check({p, "_checksum"},  bus.checksum,          32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int          base;
        int          we0;
        int          addr_err;
        int          data_err;
        logic [31:0] w;
        logic [31:0] sum;

        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.mem_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Two-word program, memory always ready.
        base = wr_cnt;
        pulse_start();
        check("t1_hold_len",  {31'b0, bus.cpu_hold}, 32'd1);
        check("t1_ready_len", {31'b0, bus.in_ready}, 32'd1);
        send_word(32'd2);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        wait_end();
        check("t1_wr_cnt", 32'(wr_cnt - base), 32'd2);
        check("t1_addr0",  wa[base],           32'h0000_0000);
        check("t1_data0",  wd[base],           32'h0000_0013);
        check("t1_addr1",  wa[base+1],         32'h0000_0004);
        check("t1_data1",  wd[base+1],         32'h0010_0093);
        check("t1_done",   {31'b0, bus.done},  32'd1);
        check("t1_csum",   bus.checksum,       32'h0010_00A6);
        check("t1_hold",   {31'b0, bus.cpu_hold}, 32'd0);

        // Zero-length load.
        base = wr_cnt;
        we0  = we_cycles;
        pulse_start();
        check("t2_done_cleared", {31'b0, bus.done}, 32'd0);
        send_word(32'd0);
        check("t2_done", {31'b0, bus.done}, 32'd1);
        tick();
        check("t2_no_we",  32'(we_cycles - we0), 32'd0);
        check("t2_wr_cnt", 32'(wr_cnt - base),   32'd0);
        check("t2_csum",   bus.checksum,         32'd0);

        // Oversize length (4097) is rejected, then a new start clears the error.
        we0 = we_cycles;
        pulse_start();
        send_word(32'h0000_1001);
        check("t3_error", {31'b0, bus.error},    32'd1);
        check("t3_done",  {31'b0, bus.done},     32'd0);
        check("t3_hold",  {31'b0, bus.cpu_hold}, 32'd0);
        repeat (3) tick();
        check("t3_no_we", 32'(we_cycles - we0), 32'd0);
        check("t3_error_sticky", {31'b0, bus.error}, 32'd1);
        pulse_start();
        check("t3_error_clr", {31'b0, bus.error},    32'd0);
        check("t3_len_ready", {31'b0, bus.in_ready}, 32'd1);
        send_word(32'd0);
        check("t3_done_after", {31'b0, bus.done}, 32'd1);

        // Memory back-pressure on word 0 with a byte offered during the stall.
        base = wr_cnt;
        bus.mem_ready = 1'b0;
        pulse_start();
        send_word(32'd2);
        send_word(32'h0000_0013);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h93;
        for (int k = 0; k < 4; k++) begin
            check("t4_we_held",    {31'b0, bus.mem_we},   32'd1);
            check("t4_addr_held",  bus.mem_addr,          32'h0000_0000);
            check("t4_data_held",  bus.mem_wdata,         32'h0000_0013);
            check("t4_ready_low",  {31'b0, bus.in_ready}, 32'd0);
            if (k < 3) tick();
        end
        bus.mem_ready = 1'b1;
        bus.in_valid  = 1'b0;
        send_word(32'h0010_0093);
        wait_end();
        check("t4_wr_cnt", 32'(wr_cnt - base), 32'd2);
        check("t4_addr0",  wa[base],           32'h0000_0000);
        check("t4_data0",  wd[base],           32'h0000_0013);
        check("t4_addr1",  wa[base+1],         32'h0000_0004);
        check("t4_data1",  wd[base+1],         32'h0010_0093);
        check("t4_csum",   bus.checksum,       32'h0010_00A6);

        // Reset in the middle of a payload word, then a fresh load.
        base = wr_cnt;
        pulse_start();
        send_word(32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        tick();
        check_reset("t5_rst");
        rst_n = 1'b1;
        tick();
        pulse_start();
        send_word(32'd1);
        send_word(32'hDEAD_BEEF);
        wait_end();
        check("t5_wr_cnt", 32'(wr_cnt - base), 32'd1);
        check("t5_addr0",  wa[base],           32'h0000_0000);
        check("t5_data0",  wd[base],           32'hDEAD_BEEF);
        check("t5_csum",   bus.checksum,       32'hDEAD_BEEF);
        check("t5_done",   {31'b0, bus.done},  32'd1);

        // Full-depth load with stream gaps and stray start pulses.
        base = wr_cnt;
        sum  = 32'd0;
        pulse_start();
        send_word(32'd4096);
        for (int i = 0; i < 4096; i++) begin
            w   = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
            sum = sum + w;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.start = ($urandom_range(0, 7) == 0);
                    tick();
                    bus.start = 1'b0;
                end
                send_byte(w[8*k +: 8]);
            end
        end
        wait_end();
        addr_err = 0;
        data_err = 0;
        for (int i = 0; i < 4096; i++) begin
            w = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
            if (wa[base+i] !== 32'(4 * i)) addr_err++;
            if (wd[base+i] !== w)          data_err++;
        end
        check("t6_wr_cnt",    32'(wr_cnt - base), 32'd4096);
        check("t6_addr_errs", 32'(addr_err),      32'd0);
        check("t6_data_errs", 32'(data_err),      32'd0);
        check("t6_last_addr", wa[base+4095],      32'h0000_3FFC);
        check("t6_csum",      bus.checksum,       sum);
        check("t6_done",      {31'b0, bus.done},  32'd1);
        check("t6_hold",      {31'b0, bus.cpu_hold}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
